// File: rtl/aes_io_bridge.sv
`timescale 1ns/1ps
// aes_io_bridge: host beat interface to an AES core.
// Assembles key/data blocks from BUS_W beats (MSB-first), hands blocks to the
// core with a valid/ready handshake, and unloads results beat by beat.
module aes_io_bridge #(
    parameter int BUS_W = 8,
    parameter int BLK_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cmd,
    input  logic [BUS_W-1:0] din,
    output logic             interface_ready,
    output logic             data_ok,
    output logic [BUS_W-1:0] dout,
    output logic             err,
    output logic [BLK_W-1:0] key,
    output logic             key_valid,
    output logic [BLK_W-1:0] blk,
    output logic             blk_valid,
    input  logic             blk_ready,
    input  logic [BLK_W-1:0] res,
    input  logic             res_valid
);

    localparam int BEATS = BLK_W / BUS_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, LD_KEY, LD_DATA, WAIT_ACC, WAIT_RES, UNLOAD
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_KEY  = 2'b01,
        CMD_DATA = 2'b10,
        CMD_ACK  = 2'b11
    } cmd_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BLK_W-1:0] r_shift;
    logic [BLK_W-1:0] r_key;
    logic [BLK_W-1:0] r_blk;
    logic [BLK_W-1:0] r_obuf;
    logic             r_key_valid;
    logic             r_blk_valid;
    logic             r_data_ok;
    logic             r_err;

    logic             w_capture;
    logic             w_key_done;
    logic             w_blk_done;
    logic             w_abort;
    logic             w_handshake;
    logic             w_res_take;
    logic             w_ack;
    logic             w_ack_last;
    logic [BLK_W-1:0] w_beat_in;

    assign w_beat_in = {r_shift[BLK_W-BUS_W-1:0], din};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle event decode
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_key_done   = 1'b0;
        w_blk_done   = 1'b0;
        w_abort      = 1'b0;
        w_handshake  = 1'b0;
        w_res_take   = 1'b0;
        w_ack        = 1'b0;
        w_ack_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd == CMD_KEY) begin
                    w_capture    = 1'b1;
                    w_next_state = LD_KEY;
                end else if (cmd == CMD_DATA) begin
                    w_capture    = 1'b1;
                    w_next_state = LD_DATA;
                end
            end
            LD_KEY: begin
                if (cmd == CMD_KEY) begin
                    w_capture = 1'b1;
                    if (r_cnt == LAST) begin
                        w_key_done   = 1'b1;
                        w_next_state = IDLE;
                    end
                end else if (cmd != CMD_NOP) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            LD_DATA: begin
                if (cmd == CMD_DATA) begin
                    w_capture = 1'b1;
                    if (r_cnt == LAST) begin
                        w_blk_done   = 1'b1;
                        w_next_state = WAIT_ACC;
                    end
                end else if (cmd != CMD_NOP) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            WAIT_ACC: begin
                if (blk_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    w_res_take   = 1'b1;
                    w_next_state = UNLOAD;
                end
            end
            UNLOAD: begin
                if (cmd == CMD_ACK) begin
                    w_ack = 1'b1;
                    if (r_cnt == LAST) begin
                        w_ack_last   = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: beat assembly, key/block registers, result unload buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_key       <= '0;
            r_blk       <= '0;
            r_obuf      <= '0;
            r_key_valid <= 1'b0;
            r_blk_valid <= 1'b0;
            r_data_ok   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_key_valid <= w_key_done;
            r_err       <= w_abort;

            if (w_capture) begin
                r_shift <= w_beat_in;
                r_cnt   <= (w_key_done || w_blk_done) ? '0 : r_cnt + 1'b1;
            end
            if (w_key_done) begin
                r_key <= w_beat_in;
            end
            if (w_blk_done) begin
                r_blk       <= w_beat_in;
                r_blk_valid <= 1'b1;
            end
            if (w_abort) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end
            if (w_handshake) begin
                r_blk_valid <= 1'b0;
            end
            if (w_res_take) begin
                r_obuf    <= res;
                r_data_ok <= 1'b1;
                r_cnt     <= '0;
            end
            if (w_ack) begin
                if (w_ack_last) begin
                    r_obuf    <= '0;
                    r_data_ok <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_obuf <= {r_obuf[BLK_W-BUS_W-1:0], {BUS_W{1'b0}}};
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign interface_ready = (r_state == IDLE) || (r_state == LD_KEY) || (r_state == LD_DATA);
    assign data_ok         = r_data_ok;
    assign dout            = r_data_ok ? r_obuf[BLK_W-1 -: BUS_W] : '0;
    assign err             = r_err;
    assign key             = r_key;
    assign key_valid       = r_key_valid;
    assign blk             = r_blk;
    assign blk_valid       = r_blk_valid;

endmodule

// File: tb/tb_aes_io_bridge.sv
`timescale 1ns/1ps
// Directed bench for aes_io_bridge: an 8-bit-bus instance (a_*) and a
// 32-bit-bus instance (b_*) sharing clock and reset.
module tb_aes_io_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   a_cmd = '0;
    logic [7:0]   a_din = '0;
    logic         a_ready, a_data_ok, a_err, a_key_valid, a_blk_valid;
    logic [7:0]   a_dout;
    logic [127:0] a_key, a_blk;
    logic         a_blk_ready = 1'b0;
    logic [127:0] a_res = '0;
    logic         a_res_valid = 1'b0;

    logic [1:0]   b_cmd = '0;
    logic [31:0]  b_din = '0;
    logic         b_ready, b_data_ok, b_err, b_key_valid, b_blk_valid;
    logic [31:0]  b_dout;
    logic [127:0] b_key, b_blk;
    logic         b_blk_ready = 1'b0;
    logic [127:0] b_res = '0;
    logic         b_res_valid = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    aes_io_bridge #(.BUS_W(8), .BLK_W(128)) u_dut8 (
        .clk(clk), .rst(rst), .cmd(a_cmd), .din(a_din),
        .interface_ready(a_ready), .data_ok(a_data_ok), .dout(a_dout), .err(a_err),
        .key(a_key), .key_valid(a_key_valid), .blk(a_blk), .blk_valid(a_blk_valid),
        .blk_ready(a_blk_ready), .res(a_res), .res_valid(a_res_valid)
    );

    aes_io_bridge #(.BUS_W(32), .BLK_W(128)) u_dut32 (
        .clk(clk), .rst(rst), .cmd(b_cmd), .din(b_din),
        .interface_ready(b_ready), .data_ok(b_data_ok), .dout(b_dout), .err(b_err),
        .key(b_key), .key_valid(b_key_valid), .blk(b_blk), .blk_valid(b_blk_valid),
        .blk_ready(b_blk_ready), .res(b_res), .res_valid(b_res_valid)
    );

    localparam logic [127:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KEY1 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    localparam logic [127:0] BLK0 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] RES0 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] BLK32 = 128'h0123456789ABCDEF0F1E2D3C4B5A6978;
    localparam logic [127:0] RES32 = 128'h00112233445566778899AABBCCDDEEFF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({a_ready, a_data_ok, a_err, a_key_valid, a_blk_valid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 10000", {a_ready, a_data_ok, a_err, a_key_valid, a_blk_valid});
        end
        n_cmp++;
        if ({a_key, a_blk, a_dout} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: key=%h blk=%h dout=%h want all 0", a_key, a_blk, a_dout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_key_load();
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            a_cmd = 2'b01;
            a_din = 8'(i);
            tick();
            pulses += int'(a_key_valid);
        end
        n_cmp++;
        if (a_key_valid !== 1'b1 || a_key !== KEY0) begin
            n_fail++;
            $display("FAIL key_load: valid=%b key=%h want 1 %h", a_key_valid, a_key, KEY0);
        end
        a_cmd = 2'b00;
        tick();
        pulses += int'(a_key_valid);
        tick();
        pulses += int'(a_key_valid);
        n_cmp++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL key_valid_pulses: got %0d want 1", pulses);
        end
        n_cmp++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL key_ready_after: got %b want 1", a_ready);
        end
    endtask

    task automatic test_data_path();
        for (int i = 0; i < 16; i++) begin
            a_cmd = 2'b10;
            a_din = 8'(i * 17);
            tick();
        end
        a_cmd = 2'b00;
        n_cmp++;
        if (a_blk_valid !== 1'b1 || a_blk !== BLK0 || a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL blk_load: valid=%b blk=%h ready=%b want 1 %h 0", a_blk_valid, a_blk, a_ready, BLK0);
        end
        for (int c = 0; c < 5; c++) begin
            a_cmd = 2'b10;
            tick();
            n_cmp++;
            if ({a_blk_valid, a_blk} !== {1'b1, BLK0}) begin
                n_fail++;
                $display("FAIL blk_hold_%0d: valid=%b blk=%h want 1 %h", c, a_blk_valid, a_blk, BLK0);
            end
        end
        a_cmd = 2'b00;
        a_blk_ready = 1'b1;
        tick();
        a_blk_ready = 1'b0;
        n_cmp++;
        if (a_blk_valid !== 1'b0 || a_ready !== 1'b0 || a_data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake: valid=%b ready=%b data_ok=%b want 0 0 0", a_blk_valid, a_ready, a_data_ok);
        end
        a_res = RES0;
        a_res_valid = 1'b1;
        tick();
        a_res_valid = 1'b0;
        a_res = '0;
        n_cmp++;
        if (a_data_ok !== 1'b1 || a_dout !== 8'h69) begin
            n_fail++;
            $display("FAIL res_first: data_ok=%b dout=%h want 1 69", a_data_ok, a_dout);
        end
        a_cmd = 2'b01;
        tick();
        n_cmp++;
        if (a_dout !== 8'h69 || a_err !== 1'b0 || a_data_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL unload_hold: dout=%h err=%b data_ok=%b want 69 0 1", a_dout, a_err, a_data_ok);
        end
        a_cmd = 2'b11;
        tick();
        n_cmp++;
        if (a_dout !== 8'hC4) begin
            n_fail++;
            $display("FAIL unload_second: dout=%h want c4", a_dout);
        end
        for (int k = 2; k <= 16; k++) begin
            logic [7:0] exp_b;
            a_cmd = 2'b11;
            tick();
            exp_b = (k < 16) ? RES0[127 - 8*k -: 8] : 8'h00;
            n_cmp++;
            if (a_data_ok !== (k < 16) || a_dout !== exp_b) begin
                n_fail++;
                $display("FAIL unload_ack_%0d: data_ok=%b dout=%h want %b %h", k, a_data_ok, a_dout, (k < 16), exp_b);
            end
        end
        a_cmd = 2'b00;
        tick();
        n_cmp++;
        if (a_ready !== 1'b1 || a_key !== KEY0) begin
            n_fail++;
            $display("FAIL after_unload: ready=%b key=%h want 1 %h", a_ready, a_key, KEY0);
        end
        a_res = RES0;
        a_res_valid = 1'b1;
        tick();
        a_res_valid = 1'b0;
        tick();
        n_cmp++;
        if (a_data_ok !== 1'b0 || a_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL res_in_idle: data_ok=%b dout=%h want 0 00", a_data_ok, a_dout);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 7; i++) begin
            a_cmd = 2'b01;
            a_din = 8'(8'hF0 + i);
            tick();
        end
        a_cmd = 2'b10;
        a_din = 8'hEE;
        tick();
        n_cmp++;
        if (a_err !== 1'b1 || a_ready !== 1'b1 || a_key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pulse: err=%b ready=%b key_valid=%b want 1 1 0", a_err, a_ready, a_key_valid);
        end
        a_cmd = 2'b00;
        tick();
        n_cmp++;
        if (a_err !== 1'b0 || a_key !== KEY0 || a_blk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: err=%b key=%h blk_valid=%b want 0 %h 0", a_err, a_key, a_blk_valid, KEY0);
        end
        for (int i = 0; i < 16; i++) begin
            a_cmd = 2'b01;
            a_din = 8'(8'hA0 + i);
            tick();
        end
        a_cmd = 2'b00;
        n_cmp++;
        if (a_key_valid !== 1'b1 || a_key !== KEY1) begin
            n_fail++;
            $display("FAIL abort_reload: valid=%b key=%h want 1 %h", a_key_valid, a_key, KEY1);
        end
        tick();
    endtask

    task automatic test_stall_w32();
        logic [31:0] words [4];
        int acks;
        words[0] = 32'h01234567;
        words[1] = 32'h89ABCDEF;
        words[2] = 32'h0F1E2D3C;
        words[3] = 32'h4B5A6978;
        for (int i = 0; i < 4; i++) begin
            b_cmd = 2'b10;
            b_din = words[i];
            tick();
            b_cmd = 2'b00;
            b_din = 32'hDEADBEEF;
            tick();
            tick();
            if (i == 1) begin
                n_cmp++;
                if (b_ready !== 1'b1 || b_blk_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL w32_stall_ready: ready=%b blk_valid=%b want 1 0", b_ready, b_blk_valid);
                end
            end
        end
        n_cmp++;
        if (b_blk_valid !== 1'b1 || b_blk !== BLK32) begin
            n_fail++;
            $display("FAIL w32_blk: valid=%b blk=%h want 1 %h", b_blk_valid, b_blk, BLK32);
        end
        b_blk_ready = 1'b1;
        tick();
        b_blk_ready = 1'b0;
        b_res = RES32;
        b_res_valid = 1'b1;
        tick();
        b_res_valid = 1'b0;
        n_cmp++;
        if (b_data_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL w32_data_ok: got %b want 1", b_data_ok);
        end
        acks = 0;
        while (b_data_ok === 1'b1 && acks < 10) begin
            n_cmp++;
            if (b_dout !== RES32[127 - 32*acks -: 32]) begin
                n_fail++;
                $display("FAIL w32_dout_%0d: got %h want %h", acks, b_dout, RES32[127 - 32*acks -: 32]);
            end
            b_cmd = 2'b11;
            tick();
            acks++;
        end
        b_cmd = 2'b00;
        n_cmp++;
        if (acks !== 4 || b_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL w32_ack_count: acks=%0d dout=%h want 4 0", acks, b_dout);
        end
    endtask

    task automatic test_reset_mid_unload();
        for (int i = 0; i < 16; i++) begin
            a_cmd = 2'b10;
            a_din = 8'(8'h30 + i);
            tick();
        end
        a_cmd = 2'b00;
        a_blk_ready = 1'b1;
        tick();
        a_blk_ready = 1'b0;
        a_res = RES0;
        a_res_valid = 1'b1;
        tick();
        a_res_valid = 1'b0;
        a_cmd = 2'b11;
        tick();
        tick();
        a_cmd = 2'b00;
        n_cmp++;
        if (a_data_ok !== 1'b1 || a_dout !== 8'hE0) begin
            n_fail++;
            $display("FAIL rst_pre_unload: data_ok=%b dout=%h want 1 e0", a_data_ok, a_dout);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_data_ok !== 1'b0 || a_dout !== 8'h00 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_immediate: data_ok=%b dout=%h ready=%b want 0 00 1", a_data_ok, a_dout, a_ready);
        end
        n_cmp++;
        if (a_key !== '0 || a_blk !== '0 || a_blk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_regs: key=%h blk=%h blk_valid=%b want 0 0 0", a_key, a_blk, a_blk_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({a_err, a_key_valid, a_blk_valid, a_data_ok} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_release_pulses: got %b want 0000", {a_err, a_key_valid, a_blk_valid, a_data_ok});
        end
        a_res = RES0;
        a_res_valid = 1'b1;
        tick();
        a_res_valid = 1'b0;
        tick();
        n_cmp++;
        if (a_data_ok !== 1'b0 || a_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_res_ignored: data_ok=%b dout=%h want 0 00", a_data_ok, a_dout);
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_data_path();
        test_abort();
        test_stall_w32();
        test_reset_mid_unload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_io_bridge.md
AES_IO_BRIDGE -- requirements
Module: aes_io_bridge

Interface
REQ-001 The block SHALL have parameter BUS_W, default 8, giving the host data-bus width in bits; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter BLK_W, default 128, giving the AES block and key width in bits; BLK_W SHALL be a multiple of BUS_W with BEATS = BLK_W/BUS_W >= 2.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd  in  2  host command: 00 idle/stall, 01 key beat, 10 data beat, 11 result-beat acknowledge.
REQ-006 din  in  BUS_W  host write beat.
REQ-007 interface_ready  out  1  high when the host may issue cmd 01 or 10.
REQ-008 data_ok  out  1  high while dout holds a valid result beat.
REQ-009 dout  out  BUS_W  current result beat, MSB-first.
REQ-010 err  out  1  one-cycle pulse on a protocol abort.
REQ-011 key  out  BLK_W  assembled key to the core.
REQ-012 key_valid  out  1  one-cycle pulse; key is valid that cycle.
REQ-013 blk  out  BLK_W  assembled input block to the core.
REQ-014 blk_valid  out  1  input block valid; held until blk_ready.
REQ-015 blk_ready  in  1  core accepts blk when blk_valid and blk_ready are both high.
REQ-016 res  in  BLK_W  core result.
REQ-017 res_valid  in  1  one-cycle pulse; res is valid that cycle.

Function
REQ-018 The FSM SHALL have states IDLE, LD_KEY, LD_DATA, WAIT_ACC, WAIT_RES and UNLOAD, with a beat counter of width clog2(BEATS).
REQ-019 interface_ready SHALL be 1 in IDLE, LD_KEY and LD_DATA, and 0 in all other states.
REQ-020 A beat SHALL be captured on every cycle with interface_ready=1 and cmd=01 or 10; the first beat fills the most-significant BUS_W bits, and the buffer shifts left by BUS_W per beat.
REQ-021 In IDLE: cmd=01 captures beat 0 and moves to LD_KEY; cmd=10 captures beat 0 and moves to LD_DATA; cmd=00 and cmd=11 are ignored.
REQ-022 In LD_KEY and LD_DATA, cmd=00 SHALL stall with no capture and no counter change; there SHALL be no timeout.
REQ-023 On the last beat (counter = BEATS-1) in LD_KEY: key updates and key_valid pulses in the following cycle, and the state returns to IDLE.
REQ-024 On the last beat in LD_DATA: blk updates, blk_valid rises in the following cycle, and the state moves to WAIT_ACC.
REQ-025 In LD_KEY a cmd of 10 or 11, and in LD_DATA a cmd of 01 or 11, SHALL abort the load: partial data is discarded, the counter clears, err pulses for one cycle, the state returns to IDLE, and the offending beat is not captured.
REQ-026 In WAIT_ACC, blk_valid SHALL be held with blk stable until blk_ready=1; the handshake cycle moves the state to WAIT_RES and drops blk_valid in the next cycle.
REQ-027 In WAIT_RES, the cycle with res_valid=1 SHALL latch res into the output buffer; the state moves to UNLOAD, with data_ok=1 and dout = res MSB beat in the next cycle.
REQ-028 res_valid outside WAIT_RES SHALL be ignored.
REQ-029 In UNLOAD, each cycle with cmd=11 SHALL advance dout to the next beat in the following cycle; cmd 00, 01 and 10 hold dout with no error.
REQ-030 cmd=11 on beat BEATS-1 SHALL drop data_ok in the next cycle and return the state to IDLE.
REQ-031 Host commands in WAIT_ACC and WAIT_RES SHALL be ignored.
REQ-032 The key register SHALL persist across data blocks; no reload is required per block.
REQ-033 dout SHALL be 0 whenever data_ok=0.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, counter 0, key=0, blk=0, output buffer 0, key_valid=0, blk_valid=0, data_ok=0, err=0, dout=0, interface_ready=1.
REQ-035 Reset asserted mid-load, mid-handshake or mid-unload SHALL discard all partial state, with no pulses generated on deassertion.

Verification
REQ-036 BUS_W=8: 16 beats of cmd=01 with din=00..0F -> key=000102..0F and key_valid pulses exactly once, one cycle after beat 16.
REQ-037 BUS_W=8: 16 beats of cmd=10 with din=00,11..FF, blk_ready held 0 for 5 cycles -> blk_valid stays high and blk stable; blk_ready=1 -> WAIT_RES; res_valid with res=69C4E0D8..C55A -> data_ok=1, dout=69, then C4 after one cmd=11; data_ok drops after the 16th ack.
REQ-038 BUS_W=8: 7 key beats, then cmd=10 -> err pulses once, interface_ready stays 1, and a following 16-beat key load yields the correct key.
REQ-039 BUS_W=32: 4 data beats with cmd=00 stalls interleaved -> blk identical to the unstalled load; unload takes exactly 4 acks.
REQ-040 Reset asserted during the 3rd unload beat -> data_ok=0, dout=0 and interface_ready=1 immediately; a res_valid after reset produces no data_ok.
